avr_sram_bridge: RTL and testbench

Parametrised AVR-to-SRAM bridge: the next-generation replacement for the fixed 21-bit shift-register plus bus FSM pair. A serial shift port loads the SRAM address, and a command port issues single read or write accesses. Access strobes have programmable wait states, and the address can auto-increment after each access. The block sits between the AVR pins and the SRAM pins. It exposes split data buses; tri-stating is done one level up using sram_data_oe.

---
 rtl/avr_sram_bridge.sv | 269 ++++++++++++++++++++++++++
 tb/tb_avr_sram_bridge.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/avr_sram_bridge.sv
// AVR-to-SRAM bridge.
// A serial port shifts in the SRAM address and a command port launches single
// read or write accesses with programmable strobe wait states. Every SRAM-side
// output comes straight from a flop. The data bus is split, and tri-stating
// happens one level up using sram_data_oe.

module avr_sram_bridge #(
  parameter int ADDR_WIDTH  = 21,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  avr_clk,
  input  logic                  avr_reset,
  input  logic                  avr_si,
  input  logic                  avr_sreg_en,
  input  logic [2:0]            avr_ctrl,
  input  logic                  avr_strobe,
  input  logic [DATA_WIDTH-1:0] avr_wdata,
  output logic [DATA_WIDTH-1:0] avr_rdata,
  output logic                  avr_rvalid,
  output logic                  avr_busy,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data_out,
  input  logic [DATA_WIDTH-1:0] sram_data_in,
  output logic                  sram_data_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n
);

  // Bus FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Command codes; code 7 is reserved and falls through as a NOP
  localparam logic [2:0] CMD_NOP       = 3'd0;
  localparam logic [2:0] CMD_READ      = 3'd1;
  localparam logic [2:0] CMD_WRITE     = 3'd2;
  localparam logic [2:0] CMD_READ_INC  = 3'd3;
  localparam logic [2:0] CMD_WRITE_INC = 3'd4;
  localparam logic [2:0] CMD_ADDR_INC  = 3'd5;
  localparam logic [2:0] CMD_ADDR_CLR  = 3'd6;

  // The strobe counter runs from WAIT_STATES down to zero (WAIT_STATES+1 cycles)
  localparam logic [3:0]            WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  logic [1:0]            state_r;
  logic [3:0]            wait_cnt_r;
  logic                  is_write_r;
  logic                  is_inc_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  rvalid_r;
  logic                  busy_r;
  logic                  data_oe_r;
  logic                  ce_n_r;
  logic                  oe_n_r;
  logic                  we_n_r;

  logic idle_s;
  logic shift_s;
  logic accept_s;
  logic strobe_last_s;
  logic hold_s;
  logic acc_s;
  logic acc_write_s;
  logic acc_inc_s;
  logic cmd_inc_s;
  logic cmd_clr_s;

  // A shift request in IDLE takes priority over a command in the same cycle
  assign idle_s        = (state_r == ST_IDLE);
  assign shift_s       = idle_s && avr_sreg_en;
  assign accept_s      = idle_s && avr_strobe && !avr_sreg_en;
  assign strobe_last_s = (state_r == ST_STROBE) && (wait_cnt_r == 4'd0);
  assign hold_s        = (state_r == ST_HOLD);

  // Decode an accepted command into access or address-only actions
  always_comb begin
    acc_s       = 1'b0;
    acc_write_s = 1'b0;
    acc_inc_s   = 1'b0;
    cmd_inc_s   = 1'b0;
    cmd_clr_s   = 1'b0;
    if (accept_s) begin
      case (avr_ctrl)
        CMD_NOP: begin
          acc_s = 1'b0;
        end
        CMD_READ: begin
          acc_s = 1'b1;
        end
        CMD_WRITE: begin
          acc_s       = 1'b1;
          acc_write_s = 1'b1;
        end
        CMD_READ_INC: begin
          acc_s     = 1'b1;
          acc_inc_s = 1'b1;
        end
        CMD_WRITE_INC: begin
          acc_s       = 1'b1;
          acc_write_s = 1'b1;
          acc_inc_s   = 1'b1;
        end
        CMD_ADDR_INC: begin
          cmd_inc_s = 1'b1;
        end
        CMD_ADDR_CLR: begin
          cmd_clr_s = 1'b1;
        end
        default: begin
          acc_s = 1'b0;
        end
      endcase
    end else begin
      acc_s = 1'b0;
    end
  end

  // Bus FSM sequencing and the strobe wait counter
  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
      is_write_r <= 1'b0;
      is_inc_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (acc_s) begin
            state_r    <= ST_SETUP;
            is_write_r <= acc_write_s;
            is_inc_r   <= acc_inc_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          state_r    <= ST_STROBE;
          wait_cnt_r <= WAIT_INIT;
        end
        ST_STROBE: begin
          if (wait_cnt_r == 4'd0) begin
            state_r <= ST_HOLD;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        ST_HOLD: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Address register: serial shift, explicit inc/clear, post-access increment (wraps)
  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      addr_r <= ADDR_ZERO;
    end else if (shift_s) begin
      addr_r <= {addr_r[ADDR_WIDTH-2:0], avr_si};
    end else if (cmd_inc_s) begin
      addr_r <= addr_r + ADDR_ONE;
    end else if (cmd_clr_s) begin
      addr_r <= ADDR_ZERO;
    end else if (hold_s && is_inc_r) begin
      addr_r <= addr_r + ADDR_ONE;
    end else begin
      addr_r <= addr_r;
    end
  end

  // SRAM control strobes, write data and busy, all timed from the FSM edges
  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      data_out_r <= DATA_ZERO;
      ce_n_r     <= 1'b1;
      oe_n_r     <= 1'b1;
      we_n_r     <= 1'b1;
      data_oe_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else if (acc_s) begin
      data_out_r <= avr_wdata;
      ce_n_r     <= 1'b0;
      oe_n_r     <= acc_write_s;
      we_n_r     <= 1'b1;
      data_oe_r  <= acc_write_s;
      busy_r     <= 1'b1;
    end else if ((state_r == ST_SETUP) && is_write_r) begin
      we_n_r <= 1'b0;
    end else if (strobe_last_s) begin
      we_n_r <= 1'b1;
      oe_n_r <= 1'b1;
    end else if (hold_s) begin
      ce_n_r    <= 1'b1;
      data_oe_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      busy_r <= busy_r;
    end
  end

  // Read capture at the end of the strobe phase; rvalid marks the HOLD cycle
  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      rdata_r  <= DATA_ZERO;
      rvalid_r <= 1'b0;
    end else if (strobe_last_s && !is_write_r) begin
      rdata_r  <= sram_data_in;
      rvalid_r <= 1'b1;
    end else begin
      rvalid_r <= 1'b0;
    end
  end

  assign avr_rdata     = rdata_r;
  assign avr_rvalid    = rvalid_r;
  assign avr_busy      = busy_r;
  assign sram_addr     = addr_r;
  assign sram_data_out = data_out_r;
  assign sram_data_oe  = data_oe_r;
  assign sram_ce_n     = ce_n_r;
  assign sram_oe_n     = oe_n_r;
  assign sram_we_n     = we_n_r;

  avr_sram_bridge_chk u_chk (
    .clk     (avr_clk),
    .reset   (avr_reset),
    .busy    (busy_r),
    .data_oe (data_oe_r),
    .ce_n    (ce_n_r),
    .oe_n    (oe_n_r),
    .we_n    (we_n_r)
  );

endmodule

// Bus-protocol invariants for the bridge's SRAM interface.
module avr_sram_bridge_chk (
  input logic clk,
  input logic reset,
  input logic busy,
  input logic data_oe,
  input logic ce_n,
  input logic oe_n,
  input logic we_n
);

  // Write and output enables must never overlap
  a_we_oe_excl : assert property (@(posedge clk) disable iff (reset) !(!we_n && !oe_n));

  // The bridge must not drive the bus while the SRAM is driving it
  a_no_contention : assert property (@(posedge clk) disable iff (reset) !(data_oe && !oe_n));

  // An idle bridge leaves every SRAM strobe deasserted
  a_idle_quiet : assert property (@(posedge clk) disable iff (reset)
                                  !busy |-> (ce_n && oe_n && we_n && !data_oe));

endmodule

// File: tb/tb_avr_sram_bridge.sv
// Directed bench for avr_sram_bridge. Two instances share the same stimulus:
// u_* uses WAIT_STATES=1 and z_* uses WAIT_STATES=0. Expected read data is queued
// when a read is issued and compared whenever a DUT pulses rvalid.

module tb_avr_sram_bridge;

  localparam logic [2:0] CMD_NOP       = 3'd0;
  localparam logic [2:0] CMD_READ      = 3'd1;
  localparam logic [2:0] CMD_WRITE     = 3'd2;
  localparam logic [2:0] CMD_READ_INC  = 3'd3;
  localparam logic [2:0] CMD_WRITE_INC = 3'd4;
  localparam logic [2:0] CMD_ADDR_INC  = 3'd5;
  localparam logic [2:0] CMD_ADDR_CLR  = 3'd6;

  logic        clk;
  logic        rst;
  logic        si;
  logic        sreg_en;
  logic [2:0]  ctrl;
  logic        strobe;
  logic [7:0]  wdata;
  logic [7:0]  rd_val;

  logic [7:0]  u_rdata, z_rdata, u_dout, z_dout, u_din, z_din;
  logic        u_rvalid, z_rvalid, u_busy, z_busy, u_doe, z_doe;
  logic        u_ce_n, z_ce_n, u_oe_n, z_oe_n, u_we_n, z_we_n;
  logic [20:0] u_addr, z_addr;

  int n_asrt = 0;
  int n_fail = 0;
  logic [7:0] q1[$];
  logic [7:0] q0[$];

  // SRAM models: drive the read value only while selected and output-enabled
  assign u_din = (!u_ce_n && !u_oe_n) ? rd_val : 8'hFF;
  assign z_din = (!z_ce_n && !z_oe_n) ? rd_val : 8'hFF;

  avr_sram_bridge #(.ADDR_WIDTH(21), .DATA_WIDTH(8), .WAIT_STATES(1)) u_dut (
    .avr_clk(clk), .avr_reset(rst), .avr_si(si), .avr_sreg_en(sreg_en),
    .avr_ctrl(ctrl), .avr_strobe(strobe), .avr_wdata(wdata),
    .avr_rdata(u_rdata), .avr_rvalid(u_rvalid), .avr_busy(u_busy),
    .sram_addr(u_addr), .sram_data_out(u_dout), .sram_data_in(u_din),
    .sram_data_oe(u_doe), .sram_ce_n(u_ce_n), .sram_oe_n(u_oe_n), .sram_we_n(u_we_n)
  );

  avr_sram_bridge #(.ADDR_WIDTH(21), .DATA_WIDTH(8), .WAIT_STATES(0)) z_dut (
    .avr_clk(clk), .avr_reset(rst), .avr_si(si), .avr_sreg_en(sreg_en),
    .avr_ctrl(ctrl), .avr_strobe(strobe), .avr_wdata(wdata),
    .avr_rdata(z_rdata), .avr_rvalid(z_rvalid), .avr_busy(z_busy),
    .sram_addr(z_addr), .sram_data_out(z_dout), .sram_data_in(z_din),
    .sram_data_oe(z_doe), .sram_ce_n(z_ce_n), .sram_oe_n(z_oe_n), .sram_we_n(z_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock to the next falling edge, then score any read completion
  task automatic cyc();
    logic [7:0] e;
    @(negedge clk);
    if (u_rvalid) begin
      e = (q1.size() > 0) ? q1.pop_front() : 8'hxx;
      chk("u_rdata_scoreboard", 32'(u_rdata), 32'(e));
    end
    if (z_rvalid) begin
      e = (q0.size() > 0) ? q0.pop_front() : 8'hxx;
      chk("z_rdata_scoreboard", 32'(z_rdata), 32'(e));
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [7:0] d);
    ctrl = c; wdata = d; strobe = 1'b1;
    cyc();
    ctrl = CMD_NOP; strobe = 1'b0;
  endtask

  task automatic shift_addr(input logic [20:0] val, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      sreg_en = 1'b1; si = val[i];
      cyc();
    end
    sreg_en = 1'b0; si = 1'b0;
  endtask

  int ce_lo, we_lo, doe_lo, bsy, u_oe_lo, z_oe_lo, u_rv, z_rv, doe_rd;

  initial begin
    rst = 1'b1; si = 1'b0; sreg_en = 1'b0; ctrl = CMD_NOP; strobe = 1'b0;
    wdata = 8'h00; rd_val = 8'h00;
    cyc(); cyc();

    // Reset state
    chk("rst_addr", 32'(u_addr), 32'h0);
    chk("rst_ce_n", 32'(u_ce_n), 32'h1);
    chk("rst_oe_n", 32'(u_oe_n), 32'h1);
    chk("rst_we_n", 32'(u_we_n), 32'h1);
    chk("rst_busy", 32'(u_busy), 32'h0);
    chk("rst_rdata", 32'(u_rdata), 32'h0);
    chk("rst_rvalid", 32'(u_rvalid), 32'h0);
    chk("rst_data_oe", 32'(u_doe), 32'h0);
    chk("rst_data_out", 32'(u_dout), 32'h0);
    rst = 1'b0;
    cyc();

    // Serial address load, MSB first
    shift_addr(21'h1ABCDE, 21);
    chk("shift_addr_u", 32'(u_addr), 32'h1ABCDE);
    chk("shift_addr_z", 32'(z_addr), 32'h1ABCDE);
    chk("shift_strobes", 32'({u_ce_n, u_oe_n, u_we_n}), 32'h7);
    chk("shift_busy", 32'(u_busy), 32'h0);

    // WRITE_INC with one wait state
    ce_lo = 0; we_lo = 0; doe_lo = 0; bsy = 0;
    issue(CMD_WRITE_INC, 8'hA5);
    for (int i = 1; i <= 5; i++) begin
      if (!u_ce_n) ce_lo++;
      if (!u_we_n) we_lo++;
      if (u_doe) doe_lo++;
      if (u_busy) bsy++;
      if (i == 1) chk("wr_we_n_setup", 32'(u_we_n), 32'h1);
      if (i == 1) chk("wr_data_out", 32'(u_dout), 32'hA5);
      if (i == 4) chk("wr_we_n_hold", 32'(u_we_n), 32'h1);
      if (i == 4) chk("wr_addr_in_hold", 32'(u_addr), 32'h1ABCDE);
      if (i < 5) cyc();
    end
    chk("wr_ce_low_cycles", 32'(ce_lo), 32'd4);
    chk("wr_we_low_cycles", 32'(we_lo), 32'd2);
    chk("wr_data_oe_cycles", 32'(doe_lo), 32'd4);
    chk("wr_busy_cycles", 32'(bsy), 32'd4);
    chk("wr_addr_inc_u", 32'(u_addr), 32'h1ABCDF);
    chk("wr_addr_inc_z", 32'(z_addr), 32'h1ABCDF);
    chk("wr_idle_data_oe", 32'(u_doe), 32'h0);

    // READ: z has no wait states, u has one
    rd_val = 8'h3C;
    q1.push_back(8'h3C); q0.push_back(8'h3C);
    u_oe_lo = 0; z_oe_lo = 0; u_rv = 0; z_rv = 0; doe_rd = 0;
    issue(CMD_READ, 8'h00);
    for (int i = 1; i <= 6; i++) begin
      if (!u_oe_n) u_oe_lo++;
      if (!z_oe_n) z_oe_lo++;
      if (u_rvalid) u_rv++;
      if (z_rvalid) z_rv++;
      if (u_doe || z_doe) doe_rd++;
      if (i == 3) chk("rd_z_rvalid_in_hold", 32'(z_rvalid), 32'h1);
      if (i == 4) chk("rd_u_rvalid_in_hold", 32'(u_rvalid), 32'h1);
      if (i < 6) cyc();
    end
    chk("rd_z_oe_low_cycles", 32'(z_oe_lo), 32'd2);
    chk("rd_u_oe_low_cycles", 32'(u_oe_lo), 32'd3);
    chk("rd_z_rvalid_pulses", 32'(z_rv), 32'd1);
    chk("rd_u_rvalid_pulses", 32'(u_rv), 32'd1);
    chk("rd_no_data_oe", 32'(doe_rd), 32'd0);
    rd_val = 8'h00;
    issue(CMD_NOP, 8'h00);
    issue(3'd7, 8'h00);
    cyc();
    chk("rd_hold_z", 32'(z_rdata), 32'h3C);
    chk("rd_hold_u", 32'(u_rdata), 32'h3C);
    chk("rd_addr_unchanged", 32'(u_addr), 32'h1ABCDF);
    chk("rd_nop_busy", 32'(u_busy | z_busy), 32'h0);

    // READ_INC at the top address wraps; strobe and sreg_en while busy are ignored
    shift_addr(21'h1FFFFF, 21);
    rd_val = 8'h5A;
    q1.push_back(8'h5A); q0.push_back(8'h5A);
    we_lo = 0;
    issue(CMD_READ_INC, 8'h00);
    strobe = 1'b1; ctrl = CMD_WRITE; sreg_en = 1'b1; si = 1'b0;
    cyc();
    chk("busy_ign_addr_u1", 32'(u_addr), 32'h1FFFFF);
    chk("busy_ign_addr_z1", 32'(z_addr), 32'h1FFFFF);
    sreg_en = 1'b0;
    cyc();
    chk("busy_ign_addr_u2", 32'(u_addr), 32'h1FFFFF);
    chk("busy_ign_addr_z2", 32'(z_addr), 32'h1FFFFF);
    strobe = 1'b0; ctrl = CMD_NOP;
    for (int i = 0; i < 3; i++) begin
      if (!u_we_n || !z_we_n) we_lo++;
      cyc();
    end
    chk("wrap_addr_u", 32'(u_addr), 32'h0);
    chk("wrap_addr_z", 32'(z_addr), 32'h0);
    chk("wrap_no_write", 32'(we_lo), 32'd0);
    chk("wrap_idle", 32'({u_busy, z_busy, u_ce_n, z_ce_n}), 32'h3);
    chk("wrap_rdata_u", 32'(u_rdata), 32'h5A);

    // Reset in the middle of a write strobe aborts the access
    issue(CMD_WRITE_INC, 8'h77);
    chk("abort_data_out", 32'(u_dout), 32'h77);
    cyc();
    chk("abort_we_low", 32'(u_we_n), 32'h0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_u_strobes", 32'({u_we_n, u_ce_n, u_doe, u_busy}), 32'hC);
    chk("abort_z_strobes", 32'({z_we_n, z_ce_n, z_doe, z_busy}), 32'hC);
    chk("abort_addr_u", 32'(u_addr), 32'h0);
    chk("abort_addr_z", 32'(z_addr), 32'h0);
    chk("abort_rvalid", 32'(u_rvalid | z_rvalid), 32'h0);
    cyc();

    // Shift beats command; then ADDR_CLR and ADDR_INC without any access
    shift_addr(21'h000005, 3);
    chk("pre_collide_addr", 32'(u_addr), 32'h5);
    sreg_en = 1'b1; si = 1'b0; strobe = 1'b1; ctrl = CMD_ADDR_CLR;
    cyc();
    sreg_en = 1'b0; strobe = 1'b0; ctrl = CMD_NOP;
    chk("collide_shift_only", 32'(u_addr), 32'hA);
    chk("collide_busy", 32'(u_busy), 32'h0);
    issue(CMD_ADDR_CLR, 8'h00);
    chk("addr_clr", 32'(u_addr), 32'h0);
    chk("addr_clr_busy", 32'(u_busy), 32'h0);
    issue(CMD_ADDR_INC, 8'h00);
    chk("addr_inc_u", 32'(u_addr), 32'h1);
    chk("addr_inc_z", 32'(z_addr), 32'h1);
    chk("addr_inc_busy", 32'(u_busy | z_busy), 32'h0);
    chk("addr_inc_ce_n", 32'(u_ce_n), 32'h1);
    cyc();
    chk("addr_ops_busy_after", 32'(u_busy), 32'h0);

    // Every queued read must have completed
    chk("sb_u_drained", 32'(q1.size()), 32'd0);
    chk("sb_z_drained", 32'(q0.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
